multi_data_sync: RTL

Multi-channel, parametrised destination-domain bus synchroniser for the UART datapath. Each channel carries a W-bit bus with a qualifying enable from a foreign clock domain. The enable goes through a STAGES-deep synchroniser chain and is converted to a single-cycle capture event. The bus is sampled on that event and held behind a valid/ready handshake, with per-channel overrun detection. It sits at every clock-domain crossing into the CLK domain, such as RX data into the register file or config words into the TX engine.

---
 rtl/multi_data_sync_pkg.sv | 13 +
 rtl/multi_data_sync_channel.sv | 70 +++++++
 rtl/multi_data_sync.sv | 56 +++++
 3 files changed

// File: rtl/multi_data_sync_pkg.sv
// rtl/multi_data_sync_pkg.sv - shared constants and event helper for multi_data_sync
package multi_data_sync_pkg;

    localparam int SYNC_MODE_LEVEL  = 0;
    localparam int SYNC_MODE_TOGGLE = 1;
    localparam int SYNC_MIN_STAGES  = 2;

    // Level sources fire on the rising edge only; toggle sources fire on any change.
    function automatic logic sync_event(input logic toggle_mode, input logic cur, input logic hist);
        return toggle_mode ? (cur ^ hist) : (cur & ~hist);
    endfunction

endpackage

// File: rtl/multi_data_sync_channel.sv
// rtl/multi_data_sync_channel.sv - one channel: enable synchroniser, capture register, handshake, overrun
module data_sync_channel
    import multi_data_sync_pkg::*;
#(
    parameter int W      = 8,
    parameter int STAGES = 2,
    parameter int TOGGLE = 0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         i_enable,
    input  logic [W-1:0] i_data,
    input  logic         i_ready,
    input  logic         i_overrun_clr,
    output logic [W-1:0] o_data,
    output logic         o_pulse,
    output logic         o_valid,
    output logic         o_overrun
);

    logic [STAGES-1:0] r_chain;
    logic              r_hist;
    logic [W-1:0]      r_data;
    logic              r_pulse;
    logic              r_valid;
    logic              r_overrun;

    logic w_event;
    logic w_capture;
    logic w_drop;
    logic w_accept;

    assign w_event   = sync_event(TOGGLE == SYNC_MODE_TOGGLE, r_chain[STAGES-1], r_hist);
    // A pending word being accepted this cycle frees the slot for a new capture.
    assign w_capture = w_event & (~r_valid | i_ready);
    assign w_drop    = w_event & r_valid & ~i_ready;
    assign w_accept  = r_valid & i_ready;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_chain   <= '0;
            r_hist    <= 1'b0;
            r_data    <= '0;
            r_pulse   <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_enable};
            r_hist  <= r_chain[STAGES-1];
            r_pulse <= w_capture;
            if (w_capture) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_pulse   = r_pulse;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/multi_data_sync.sv
// rtl/multi_data_sync.sv - CH-channel destination-domain bus synchroniser with valid/ready and overrun
module multi_data_sync
    import multi_data_sync_pkg::*;
#(
    parameter int W      = 8,
    parameter int CH     = 2,
    parameter int STAGES = 2,
    parameter int TOGGLE = 0
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CH-1:0]   bus_enable,
    input  logic [CH*W-1:0] unsync_bus,
    output logic [CH*W-1:0] sync_bus,
    output logic [CH-1:0]   enable_pulse,
    output logic [CH-1:0]   sync_valid,
    input  logic [CH-1:0]   sync_ready,
    output logic [CH-1:0]   overrun,
    input  logic [CH-1:0]   overrun_clr
);

    generate
        if (STAGES < SYNC_MIN_STAGES) begin : g_bad_stages
            $error("multi_data_sync: STAGES must be at least %0d", SYNC_MIN_STAGES);
        end
        if (CH < 1) begin : g_bad_ch
            $error("multi_data_sync: CH must be at least 1");
        end
        if (W < 1) begin : g_bad_w
            $error("multi_data_sync: W must be at least 1");
        end
        if (TOGGLE != SYNC_MODE_LEVEL && TOGGLE != SYNC_MODE_TOGGLE) begin : g_bad_mode
            $error("multi_data_sync: TOGGLE must be 0 or 1");
        end
    endgenerate

    for (genvar c = 0; c < CH; c++) begin : g_ch
        data_sync_channel #(
            .W      (W),
            .STAGES (STAGES),
            .TOGGLE (TOGGLE)
        ) u_channel (
            .CLK           (CLK),
            .RST           (RST),
            .i_enable      (bus_enable[c]),
            .i_data        (unsync_bus[c*W +: W]),
            .i_ready       (sync_ready[c]),
            .i_overrun_clr (overrun_clr[c]),
            .o_data        (sync_bus[c*W +: W]),
            .o_pulse       (enable_pulse[c]),
            .o_valid       (sync_valid[c]),
            .o_overrun     (overrun[c])
        );
    end

endmodule
